// File: rtl/pulse_train_pkg.sv
// Shared state type and default sizing for the pulse train generator.
package pulse_train_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } pt_state_e;

endpackage

// File: rtl/pulse_train_if.sv
// Control/status bundle of pulse_train_gen; DONE, IRQ and DONE_CLR exist only
// when PULSE_TRAIN_DONE_IRQ_EN is defined.
interface pulse_train_if
  import pulse_train_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
);

  logic [NUM_CH-1:0]       START;
  logic [NUM_CH-1:0]       STOP;
  logic [NUM_CH*CNT_W-1:0] DELAY_CFG;
  logic [NUM_CH*CNT_W-1:0] HIGH_CFG;
  logic [NUM_CH*CNT_W-1:0] LOW_CFG;
  logic [NUM_CH*CNT_W-1:0] COUNT_CFG;
  logic [NUM_CH-1:0]       PULSE;
  logic [NUM_CH-1:0]       BUSY;
`ifdef PULSE_TRAIN_DONE_IRQ_EN
  logic [NUM_CH-1:0]       DONE;
  logic                    IRQ;
  logic [NUM_CH-1:0]       DONE_CLR;

  modport master (
    output START, STOP, DELAY_CFG, HIGH_CFG, LOW_CFG, COUNT_CFG, DONE_CLR,
    input  PULSE, BUSY, DONE, IRQ
  );
  modport slave (
    input  START, STOP, DELAY_CFG, HIGH_CFG, LOW_CFG, COUNT_CFG, DONE_CLR,
    output PULSE, BUSY, DONE, IRQ
  );
`else
  modport master (
    output START, STOP, DELAY_CFG, HIGH_CFG, LOW_CFG, COUNT_CFG,
    input  PULSE, BUSY
  );
  modport slave (
    input  START, STOP, DELAY_CFG, HIGH_CFG, LOW_CFG, COUNT_CFG,
    output PULSE, BUSY
  );
`endif

endinterface

// File: rtl/pulse_train_ch.sv
// One pulse channel: IDLE/DELAY/HIGH/LOW FSM with phase and pulse counters.
// PULSE_TRAIN_DONE_IRQ_EN adds the sticky completion flag.
module pulse_train_ch
  import pulse_train_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter bit PULSE_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] delay_cfg,
  input  logic [CNT_W-1:0] high_cfg,
  input  logic [CNT_W-1:0] low_cfg,
  input  logic [CNT_W-1:0] count_cfg,
  output logic             pulse,
  output logic             busy
`ifdef PULSE_TRAIN_DONE_IRQ_EN
  ,
  input  logic             done_clr,
  output logic             done
`endif
);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t ONE = cnt_t'(1);

  // A zero width behaves as one cycle, so its reload value is also zero.
  function automatic cnt_t phase_load(input cnt_t v);
    return (v == '0) ? '0 : v - ONE;
  endfunction

  pt_state_e state_q, state_d;
  cnt_t      cnt_q, cnt_d;
  cnt_t      pcnt_q, pcnt_d;
  cnt_t      high_q, high_d;
  cnt_t      low_q, low_d;
  logic      pulse_q, pulse_d;
  logic      busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    high_d  = high_q;
    low_d   = low_q;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      pcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            high_d = phase_load(high_cfg);
            low_d  = phase_load(low_cfg);
            pcnt_d = count_cfg;
            if (delay_cfg == '0) begin
              state_d = HIGH;
              cnt_d   = phase_load(high_cfg);
            end else begin
              state_d = DELAY;
              cnt_d   = delay_cfg - ONE;
            end
          end
        end
        DELAY: begin
          if (cnt_q == '0) begin
            state_d = HIGH;
            cnt_d   = high_q;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        HIGH: begin
          if (cnt_q == '0) begin
            state_d = LOW;
            cnt_d   = low_q;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        LOW: begin
          // A pulse count of zero marks continuous mode and is never decremented.
          if (cnt_q == '0) begin
            if (pcnt_q == ONE) begin
              state_d = IDLE;
              pcnt_d  = '0;
            end else begin
              state_d = HIGH;
              cnt_d   = high_q;
              if (pcnt_q != '0) begin
                pcnt_d = pcnt_q - ONE;
              end
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    pulse_d = (state_q == HIGH) ? PULSE_POL : ~PULSE_POL;
    busy_d  = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      high_q  <= '0;
      low_q   <= '0;
      pulse_q <= ~PULSE_POL;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      high_q  <= high_d;
      low_q   <= low_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  assign pulse = pulse_q;
  assign busy  = busy_q;

`ifdef PULSE_TRAIN_DONE_IRQ_EN
  logic done_q, done_d;
  logic natural_end;

  // Only the last LOW cycle of a finite train counts; STOP suppresses it.
  assign natural_end = (state_q == LOW) && (cnt_q == '0) && (pcnt_q == ONE) && !stop;

  always_comb begin
    done_d = natural_end | (done_q & ~done_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;
`endif

endmodule

// File: rtl/pulse_train_gen.sv
// Multi-channel pulse train generator: NUM_CH independent pulse_train_ch instances.
// PULSE_TRAIN_DONE_IRQ_EN adds per-channel DONE flags and a combined IRQ.
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter bit PULSE_POL = 1'b1
) (
  input logic          CLK,
  input logic          RESETN,
  pulse_train_if.slave io
);

  logic [NUM_CH-1:0] pulse_w;
  logic [NUM_CH-1:0] busy_w;
`ifdef PULSE_TRAIN_DONE_IRQ_EN
  logic [NUM_CH-1:0] done_w;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pulse_train_ch #(
      .CNT_W     (CNT_W),
      .PULSE_POL (PULSE_POL)
    ) u_ch (
      .clk       (CLK),
      .rst_n     (RESETN),
      .start     (io.START[gi]),
      .stop      (io.STOP[gi]),
      .delay_cfg (io.DELAY_CFG[gi*CNT_W +: CNT_W]),
      .high_cfg  (io.HIGH_CFG[gi*CNT_W +: CNT_W]),
      .low_cfg   (io.LOW_CFG[gi*CNT_W +: CNT_W]),
      .count_cfg (io.COUNT_CFG[gi*CNT_W +: CNT_W]),
      .pulse     (pulse_w[gi]),
      .busy      (busy_w[gi])
`ifdef PULSE_TRAIN_DONE_IRQ_EN
      ,
      .done_clr  (io.DONE_CLR[gi]),
      .done      (done_w[gi])
`endif
    );
  end

  assign io.PULSE = pulse_w;
  assign io.BUSY  = busy_w;

`ifdef PULSE_TRAIN_DONE_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = |done_w;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign io.DONE = done_w;
  assign io.IRQ  = irq_q;
`endif

endmodule
